bcd_counter_2digits: RTL and testbench

//  - Two-digit packed-BCD event counter, range 00..99, advanced by a single-cycle enable (e.g. a debounced button tick).
//  - Used in front-panel/alarm designs to count events and flag rollover.
//  - Optional built-in 2-digit multiplexed seven-segment driver.

---
 rtl/bcd_counter_2digits.sv | 112 +++++++++++
 tb/tb_bcd_counter_2digits.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/bcd_counter_2digits.sv
// Two-digit packed-BCD event counter (00..99) with a rollover flag.
// Optional two-digit multiplexed seven-segment driver enabled by `define SEG_DISPLAY_EN.
module bcd_counter_2digits #(
    parameter int N           = 8,
    parameter int REFRESH_DIV = 125_000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [N-1:0] q,
    output logic         max_tick
`ifdef SEG_DISPLAY_EN
    ,
    output logic [1:0]   an,
    output logic [6:0]   seg
`endif
);

    logic [3:0] ones_q, ones_d;
    logic [3:0] tens_q, tens_d;

    // Any digit value >= 9 is treated as 9 so forced non-BCD states recover.
    always_comb begin
        ones_d = ones_q;
        tens_d = tens_q;
        if (en) begin
            if (ones_q >= 4'd9) begin
                ones_d = '0;
                tens_d = (tens_q >= 4'd9) ? 4'd0 : tens_q + 4'd1;
            end else begin
                ones_d = ones_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ones_q <= '0;
            tens_q <= '0;
        end else begin
            ones_q <= ones_d;
            tens_q <= tens_d;
        end
    end

    always_comb begin
        q      = '0;
        q[7:0] = {tens_q, ones_q};
    end

    assign max_tick = en & ({tens_q, ones_q} == 8'h99);

`ifdef SEG_DISPLAY_EN
    localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic {
        SEL_ONES = 1'b0,
        SEL_TENS = 1'b1
    } sel_e;

    logic [RW-1:0] refresh_q, refresh_d;
    sel_e          sel_q, sel_d;
    logic [1:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    digit;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'b0000001;
            4'd1:    seg_code = 7'b1001111;
            4'd2:    seg_code = 7'b0010010;
            4'd3:    seg_code = 7'b0000110;
            4'd4:    seg_code = 7'b1001100;
            4'd5:    seg_code = 7'b0100100;
            4'd6:    seg_code = 7'b0100000;
            4'd7:    seg_code = 7'b0001111;
            4'd8:    seg_code = 7'b0000000;
            default: seg_code = 7'b0000100;
        endcase
    endfunction

    always_comb begin
        refresh_d = refresh_q + RW'(1);
        sel_d     = sel_q;
        if (refresh_q == RW'(REFRESH_DIV - 1)) begin
            refresh_d = '0;
            sel_d     = (sel_q == SEL_ONES) ? SEL_TENS : SEL_ONES;
        end
        digit = (sel_q == SEL_TENS) ? tens_q : ones_q;
        an_d  = (sel_q == SEL_TENS) ? 2'b01 : 2'b10;
        seg_d = seg_code(digit);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            refresh_q <= '0;
            sel_q     <= SEL_ONES;
            an_q      <= 2'b10;
            seg_q     <= 7'b0000001;
        end else begin
            refresh_q <= refresh_d;
            sel_q     <= sel_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
`endif

endmodule

// File: tb/tb_bcd_counter_2digits.sv
// Scoreboard bench for bcd_counter_2digits: stimulus pushes expected q/max_tick per cycle,
// a monitor pops and compares; display checks run when SEG_DISPLAY_EN is defined.
module tb_bcd_counter_2digits;

    localparam int N = 12;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         en = 1'b0;
    logic [N-1:0] q;
    logic         max_tick;
`ifdef SEG_DISPLAY_EN
    logic [1:0]   an;
    logic [6:0]   seg;
`endif

    bcd_counter_2digits #(.N(N), .REFRESH_DIV(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .q        (q),
        .max_tick (max_tick)
`ifdef SEG_DISPLAY_EN
        ,
        .an       (an),
        .seg      (seg)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] q;
        logic         mt;
    } exp_t;

    exp_t q_exp[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cnt    = 0;
    bit   done   = 0;

    function automatic logic [N-1:0] pack(input int c);
        logic [N-1:0] v;
        v = '0;
        v[7:4] = 4'((c / 10) % 10);
        v[3:0] = 4'(c % 10);
        return v;
    endfunction

    // One cycle: drive inputs at the falling edge, record what the DUT should show now.
    task automatic step(input bit en_v, input bit rst_v);
        exp_t e;
        @(negedge clk);
        reset = rst_v;
        en    = en_v;
        if (!rst_v) cnt = 0;
        e.q  = pack(cnt);
        e.mt = en_v && rst_v && (cnt == 99);
        q_exp.push_back(e);
        if (rst_v && en_v) cnt = (cnt + 1) % 100;
    endtask

    task automatic run_to(input int target);
        step(1'b0, 1'b0);
        for (int i = 0; i < target; i++) step(1'b1, 1'b1);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q_exp.size() > 0) begin
                e = q_exp.pop_front();
                n_chk++;
                if (q === e.q) n_pass++;
                else $display("FAIL q: got %h expected %h at %0t", q, e.q, $time);
                n_chk++;
                if (max_tick === e.mt) n_pass++;
                else $display("FAIL max_tick: got %b expected %b (q=%h) at %0t", max_tick, e.mt, q, $time);
            end
        end
    end

`ifdef SEG_DISPLAY_EN
    function automatic logic [6:0] code_of(input int d);
        logic [6:0] t[10];
        t = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
              7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
        return t[d];
    endfunction

    task automatic check_display();
        logic [1:0] prev_an;
        int run = 0;
        int changes = 0;
        prev_an = an;
        for (int i = 0; i < 24; i++) begin
            step(1'b0, 1'b1);
            #3;
            n_chk++;
            if ((an == 2'b01 && seg === code_of(cnt / 10)) ||
                (an == 2'b10 && seg === code_of(cnt % 10))) n_pass++;
            else $display("FAIL display: an=%b seg=%b for count %0d", an, seg, cnt);
            run++;
            if (an !== prev_an) begin
                if (changes > 0) begin
                    n_chk++;
                    if (run == 4) n_pass++;
                    else $display("FAIL an_period: got %0d cycles expected 4", run);
                end
                changes++;
                run = 0;
                prev_an = an;
            end
        end
        n_chk++;
        if (changes >= 5) n_pass++;
        else $display("FAIL an_toggles: got %0d expected >= 5", changes);
    endtask
`endif

    initial begin : stimulus
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1);
            step(1'b0, 1'b1);
        end
        run_to(0);
        for (int i = 0; i < 101; i++) step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        run_to(42);
        for (int i = 0; i < 50; i++) step(1'b0, 1'b1);
        run_to(99);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        run_to(57);
        step(1'b0, 1'b1);
        // Reset pulled between edges; the monitor samples before the next rising edge.
        step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
`ifdef SEG_DISPLAY_EN
        run_to(37);
        check_display();
`endif
        for (int i = 0; i < 2000; i++)
            step(1'($urandom_range(0, 3) != 0), $urandom_range(0, 63) != 0);
        @(negedge clk);
        #4;
        n_chk++;
        if (q_exp.size() == 0) n_pass++;
        else $display("FAIL drain: %0d entries left expected 0", q_exp.size());
        done = 1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        if (!done) begin
            $display("FAIL timeout: stimulus did not complete");
            $fatal(1, "timeout");
        end
    end

endmodule
